// File: rtl/uart_rx_fifo.sv
// Wishbone-attached receive FIFO for a UART receiver: DATA/STATUS/CTRL registers,
// sticky overrun, flush, and a threshold/overrun level interrupt.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_stall_o,
    output logic        wb_err_o,
    input  logic        rx_dv_i,
    input  logic [7:0]  rx_byte_i,
    output logic        irq_o
);

    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          overrun, rx_irq_en, ovr_irq_en;
    logic [6:0]    threshold;
    logic [7:0]    thr_eff, count8;
    logic [1:0]    reg_sel;
    logic          full, empty, accept, rd_acc, wr_acc;
    logic          pop, push, flush, ovr_set, ovr_clr;
    logic [31:0]   rdata;
    logic          unused_bits;

    assign wb_stall_o = 1'b0;
    assign wb_err_o   = 1'b0;

    assign reg_sel = wb_adr_i[3:2];
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign count8  = 8'(count);
    assign accept  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign rd_acc  = accept & ~wb_we_i;
    assign wr_acc  = accept & wb_we_i;

    assign pop     = rd_acc & (reg_sel == 2'd0) & ~empty;
    assign flush   = wr_acc & (reg_sel == 2'd2) & wb_sel_i[0] & wb_dat_i[2];
    // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
    assign push    = rx_dv_i & ~flush & (~full | pop);
    assign ovr_set = rx_dv_i & ~flush & full & ~pop;
    assign ovr_clr = wr_acc & (reg_sel == 2'd1) & wb_sel_i[0] & wb_dat_i[2];

    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:15],
                           wb_dat_i[7:3], wb_sel_i[3:2]};

    always_comb begin
        thr_eff = {1'b0, threshold};
        if (threshold == 7'd0) begin
            thr_eff = 8'd1;
        end else if ({1'b0, threshold} > 8'(DEPTH)) begin
            thr_eff = 8'(DEPTH);
        end
    end

    always_comb begin
        count_nxt = count + CW'(push) - CW'(pop);
    end

    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            2'd0:    rdata = {23'd0, empty, (empty ? 8'h00 : mem[rd_ptr])};
            2'd1:    rdata = {16'd0, count8, 5'd0, overrun, full, empty};
            2'd2:    rdata = {17'd0, threshold, 5'd0, 1'b0, ovr_irq_en, rx_irq_en};
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= 32'd0;
            irq_o      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overrun    <= 1'b0;
            rx_irq_en  <= 1'b0;
            ovr_irq_en <= 1'b0;
            threshold  <= 7'd1;
        end else begin
            wb_ack_o <= accept;
            if (rd_acc) begin
                wb_dat_o <= rdata;
            end else if (wr_acc) begin
                wb_dat_o <= 32'd0;
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                count <= count_nxt;
            end

            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end

            if (wr_acc && reg_sel == 2'd2) begin
                if (wb_sel_i[0]) begin
                    rx_irq_en  <= wb_dat_i[0];
                    ovr_irq_en <= wb_dat_i[1];
                end
                if (wb_sel_i[1]) threshold <= wb_dat_i[14:8];
            end

            irq_o <= (rx_irq_en & (count8 >= thr_eff)) | (ovr_irq_en & overrun);
        end
    end

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge wb_clk_i) begin
        if (push) mem[wr_ptr] <= rx_byte_i;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: register vector table, directed corner
// sequences, and randomized traffic checked against a queue-based model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0] wb_adr_i, wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        wb_stall_o, wb_err_o;
    logic        rx_dv_i;
    logic [7:0]  rx_byte_i;
    logic        irq_o;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (wb_rst_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_we_i   (wb_we_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_i  (wb_sel_i),
        .wb_ack_o  (wb_ack_o),
        .wb_dat_o  (wb_dat_o),
        .wb_stall_o(wb_stall_o),
        .wb_err_o  (wb_err_o),
        .rx_dv_i   (rx_dv_i),
        .rx_byte_i (rx_byte_i),
        .irq_o     (irq_o)
    );

    int total = 0;
    int passed = 0;

    // Reference model: byte queue plus register shadows.
    logic [7:0] q[$];
    bit         m_ovr, m_rx_en, m_ovr_en;
    logic [6:0] m_thr;

    typedef enum {OP_PUSH, OP_READ, OP_WRITE} op_e;
    typedef struct {
        op_e         op;
        logic [31:0] adr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] exp_val;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    task automatic m_reset();
        q.delete();
        m_ovr = 0; m_rx_en = 0; m_ovr_en = 0; m_thr = 7'd1;
    endtask

    task automatic m_push(input logic [7:0] b);
        if (q.size() < DEPTH) q.push_back(b);
        else m_ovr = 1;
    endtask

    task automatic m_data(input bit dv, input logic [7:0] b, output logic [31:0] exp);
        if (q.size() == 0) begin
            exp = 32'h100;
        end else begin
            exp = {24'd0, q[0]};
            void'(q.pop_front());
        end
        if (dv) m_push(b);
    endtask

    task automatic m_ctrl_write(input logic [31:0] d, input logic [3:0] s,
                                input bit dv, input logic [7:0] b);
        if (s[0]) begin m_rx_en = d[0]; m_ovr_en = d[1]; end
        if (s[1]) m_thr = d[14:8];
        if (s[0] && d[2]) q.delete();
        else if (dv) m_push(b);
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] st;
        st = 32'd0;
        st[15:8] = 8'(q.size());
        st[2] = m_ovr;
        st[1] = (q.size() == DEPTH);
        st[0] = (q.size() == 0);
        return st;
    endfunction

    function automatic logic [31:0] m_ctrl();
        return {17'd0, m_thr, 5'd0, 1'b0, m_ovr_en, m_rx_en};
    endfunction

    function automatic logic m_irq();
        int t;
        t = int'(m_thr);
        if (t == 0) t = 1;
        if (t > DEPTH) t = DEPTH;
        return (m_rx_en && q.size() >= t) || (m_ovr_en && m_ovr);
    endfunction

    task automatic do_reset();
        wb_rst_i = 1; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; rx_dv_i = 0;
        repeat (2) @(posedge clk);
        #1;
        wb_rst_i = 0;
        m_reset();
    endtask

    task automatic push(input logic [7:0] b);
        rx_dv_i = 1; rx_byte_i = b;
        m_push(b);
        @(posedge clk);
        #1;
        rx_dv_i = 0;
    endtask

    // One idle edge first so ack from the previous access is low, then one accepted access.
    task automatic bus(input bit we, input logic [31:0] adr, input logic [31:0] d,
                       input logic [3:0] s, input bit dv, input logic [7:0] b,
                       output logic [31:0] rd);
        @(posedge clk);
        #1;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = d; wb_sel_i = s;
        rx_dv_i = dv; rx_byte_i = b;
        @(posedge clk);
        #1;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; rx_dv_i = 0;
        chk("ack", {31'd0, wb_ack_o}, 32'd1);
        rd = wb_dat_o;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, e, d;
        logic [3:0]  s;
        logic [7:0]  b;
        bit          dv;
        int          op;

        wb_rst_i = 1; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        wb_adr_i = 0; wb_dat_i = 0; wb_sel_i = 0; rx_dv_i = 0; rx_byte_i = 0;

        vecs.push_back('{OP_READ,  32'h4, 32'h0,        4'hF, 32'h0000_0001});
        vecs.push_back('{OP_READ,  32'h8, 32'h0,        4'hF, 32'h0000_0100});
        vecs.push_back('{OP_PUSH,  32'h0, 32'h41,       4'h0, 32'h0});
        vecs.push_back('{OP_PUSH,  32'h0, 32'h42,       4'h0, 32'h0});
        vecs.push_back('{OP_READ,  32'h4, 32'h0,        4'hF, 32'h0000_0200});
        vecs.push_back('{OP_READ,  32'h0, 32'h0,        4'hF, 32'h0000_0041});
        vecs.push_back('{OP_READ,  32'h0, 32'h0,        4'hF, 32'h0000_0042});
        vecs.push_back('{OP_READ,  32'h0, 32'h0,        4'hF, 32'h0000_0100});
        vecs.push_back('{OP_READ,  32'h4, 32'h0,        4'hF, 32'h0000_0001});
        vecs.push_back('{OP_WRITE, 32'hC, 32'hFFFF_FFFF, 4'hF, 32'h0});
        vecs.push_back('{OP_READ,  32'hC, 32'h0,        4'hF, 32'h0000_0000});
        vecs.push_back('{OP_WRITE, 32'h8, 32'h0000_7F07, 4'hF, 32'h0});
        vecs.push_back('{OP_READ,  32'h8, 32'h0,        4'hF, 32'h0000_7F03});
        vecs.push_back('{OP_WRITE, 32'h8, 32'h0000_0000, 4'h2, 32'h0});
        vecs.push_back('{OP_READ,  32'h8, 32'h0,        4'hF, 32'h0000_0003});
        vecs.push_back('{OP_WRITE, 32'h8, 32'h0000_0100, 4'hF, 32'h0});

        do_reset();
        chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        chk("stall_err", {30'd0, wb_stall_o, wb_err_o}, 32'd0);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_PUSH:  push(vecs[i].data[7:0]);
                OP_WRITE: bus(1, vecs[i].adr, vecs[i].data, vecs[i].sel, 0, 8'h0, r);
                default: begin
                    bus(0, vecs[i].adr, 32'h0, vecs[i].sel, 0, 8'h0, r);
                    chk($sformatf("vec%0d", i), r, vecs[i].exp_val);
                end
            endcase
        end

        // Overrun on the 17th byte, drain in order, then clear overrun.
        do_reset();
        for (int i = 0; i < 17; i++) push(8'(i));
        bus(0, 32'h4, 0, 4'hF, 0, 0, r); chk("ovr_status", r, 32'h0000_1006);
        for (int i = 0; i < 16; i++) begin
            bus(0, 32'h0, 0, 4'hF, 0, 0, r); chk($sformatf("ovr_data%0d", i), r, 32'(i));
        end
        bus(0, 32'h4, 0, 4'hF, 0, 0, r); chk("ovr_drained", r, 32'h0000_0005);
        bus(1, 32'h4, 32'h4, 4'h1, 0, 0, r);
        bus(0, 32'h4, 0, 4'hF, 0, 0, r); chk("ovr_cleared", r, 32'h0000_0001);

        // Full FIFO: push and pop on the same edge.
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        bus(0, 32'h0, 0, 4'hF, 1, 8'hAA, r); chk("full_pp_data", r, 32'h0000_0020);
        bus(0, 32'h4, 0, 4'hF, 0, 0, r); chk("full_pp_status", r, 32'h0000_1002);
        for (int i = 1; i < 16; i++) begin
            bus(0, 32'h0, 0, 4'hF, 0, 0, r); chk("full_pp_drain", r, 32'(8'h20 + i));
        end
        bus(0, 32'h0, 0, 4'hF, 0, 0, r); chk("full_pp_new", r, 32'h0000_00AA);

        // Empty FIFO: read with a push on the same edge.
        do_reset();
        bus(0, 32'h0, 0, 4'hF, 1, 8'h5A, r); chk("empty_pp_data", r, 32'h0000_0100);
        bus(0, 32'h4, 0, 4'hF, 0, 0, r); chk("empty_pp_status", r, 32'h0000_0100);
        bus(0, 32'h0, 0, 4'hF, 0, 0, r); chk("empty_pp_byte", r, 32'h0000_005A);

        // Threshold interrupt with its one-cycle latency.
        do_reset();
        bus(1, 32'h8, 32'h0000_0401, 4'hF, 0, 0, r);
        for (int i = 0; i < 3; i++) push(8'(i));
        @(posedge clk); #1;
        chk("thr_irq_3", {31'd0, irq_o}, 32'd0);
        push(8'h3);
        chk("thr_irq_lat", {31'd0, irq_o}, 32'd0);
        @(posedge clk); #1;
        chk("thr_irq_4", {31'd0, irq_o}, 32'd1);
        bus(0, 32'h0, 0, 4'hF, 0, 0, r);
        @(posedge clk); #1;
        chk("thr_irq_pop", {31'd0, irq_o}, 32'd0);

        // Flush with a push on the same edge; flush keeps overrun.
        do_reset();
        for (int i = 0; i < 5; i++) push(8'(i));
        bus(1, 32'h8, 32'h4, 4'hF, 1, 8'h77, r);
        bus(0, 32'h4, 0, 4'hF, 0, 0, r); chk("flush_status", r, 32'h0000_0001);
        bus(0, 32'h8, 0, 4'hF, 0, 0, r); chk("flush_ctrl", r, 32'h0000_0000);
        for (int i = 0; i < 17; i++) push(8'(i));
        bus(1, 32'h8, 32'h4, 4'hF, 0, 0, r);
        bus(0, 32'h4, 0, 4'hF, 0, 0, r); chk("flush_keep_ovr", r, 32'h0000_0005);

        // Reset during the ack cycle with the request still held.
        do_reset();
        for (int i = 0; i < 3; i++) push(8'(i));
        bus(1, 32'h8, 32'h0000_0101, 4'hF, 0, 0, r);
        @(posedge clk); #1;
        chk("rst_mid_irq_pre", {31'd0, irq_o}, 32'd1);
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 0; wb_sel_i = 4'hF;
        @(posedge clk); #1;
        chk("rst_mid_ack", {31'd0, wb_ack_o}, 32'd1);
        wb_rst_i = 1;
        @(posedge clk); #1;
        chk("rst_mid_noack", {31'd0, wb_ack_o}, 32'd0);
        chk("rst_mid_irq", {31'd0, irq_o}, 32'd0);
        @(posedge clk); #1;
        chk("rst_mid_noack2", {31'd0, wb_ack_o}, 32'd0);
        wb_cyc_i = 0; wb_stb_i = 0; wb_rst_i = 0;
        m_reset();
        bus(0, 32'h4, 0, 4'hF, 0, 0, r); chk("rst_mid_status", r, 32'h0000_0001);
        bus(0, 32'h8, 0, 4'hF, 0, 0, r); chk("rst_mid_ctrl", r, 32'h0000_0100);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 10);
            b  = 8'($urandom);
            dv = 1'($urandom_range(0, 1));
            case (op)
                0, 1, 2, 3: push(b);
                4, 5: begin
                    m_data(dv, b, e);
                    bus(0, 32'h0, 0, 4'hF, dv, b, r);
                    chk("rnd_data", r, e);
                end
                6: begin
                    bus(0, 32'h4, 0, 4'hF, 0, 0, r);
                    chk("rnd_status", r, m_status());
                end
                7: begin
                    d = $urandom; s = 4'($urandom);
                    bus(1, 32'h4, d, s, 0, 0, r);
                    if (s[0] && d[2]) m_ovr = 0;
                end
                8: begin
                    d = $urandom;
                    d[2] = ($urandom_range(0, 5) == 0);
                    if ($urandom_range(0, 1) == 1) d[14:8] = 7'($urandom_range(0, DEPTH + 1));
                    s = 4'($urandom); s[0] = 1'b1;
                    m_ctrl_write(d, s, dv, b);
                    bus(1, 32'h8, d, s, dv, b, r);
                end
                9: begin
                    bus(0, 32'h8, 0, 4'hF, 0, 0, r);
                    chk("rnd_ctrl", r, m_ctrl());
                end
                default: begin
                    @(posedge clk); #1;
                    chk("rnd_irq", {31'd0, irq_o}, {31'd0, m_irq()});
                end
            endcase
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of receive FIFO entries (power of two, 4..64).
REQ-002 The block SHALL have parameter AW, default $clog2(DEPTH), meaning the pointer width.
REQ-003 wb_clk_i  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 wb_rst_i  in  1  synchronous, active-high reset.
REQ-005 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic bus-cycle, strobe and write-enable inputs.
REQ-006 wb_adr_i  in  32  byte address; the block SHALL decode only bits [3:2].
REQ-007 wb_dat_i  in  32  write data.
REQ-008 wb_sel_i  in  4  byte enables.
REQ-009 wb_ack_o  out  1  access acknowledge.
REQ-010 wb_dat_o  out  32  read data.
REQ-011 wb_stall_o, wb_err_o  out  1 each  tied to 0.
REQ-012 rx_dv_i  in  1  one-cycle pulse marking a valid byte from the UART receiver.
REQ-013 rx_byte_i  in  8  received byte, qualified by rx_dv_i.
REQ-014 irq_o  out  1  level interrupt to the core.

Function
REQ-015 Register map SHALL be: 0x0 DATA (RO), 0x4 STATUS, 0x8 CTRL (RW); 0xC SHALL read 0 and ignore writes.
REQ-016 A request is accepted when cyc&stb&!wb_ack_o; wb_ack_o SHALL assert for exactly one cycle, one cycle after acceptance, and wb_dat_o SHALL be registered and valid with that ack.
REQ-017 DATA read SHALL return {23'b0, empty, head_byte}; if not empty, the head entry SHALL pop on the acceptance edge; if empty, it SHALL return 0x100 and SHALL NOT pop.
REQ-018 STATUS read SHALL return {16'b0, count[7:0], 5'b0, overrun, full, empty}; count SHALL range 0..DEPTH.
REQ-019 Writing STATUS with sel[0]=1 and bit 2=1 SHALL clear overrun; other bits SHALL be ignored.
REQ-020 CTRL SHALL hold bit 0 rx_irq_en, bit 1 ovr_irq_en (both writable when sel[0]=1), bit 2 flush (write-1, self-clearing, reads 0), and bits [14:8] threshold (writable when sel[1]=1).
REQ-021 On rx_dv_i with the FIFO not full, rx_byte_i SHALL be written at the tail, and count SHALL increment on the same edge.
REQ-022 On rx_dv_i with the FIFO full and no pop on that edge, the byte SHALL be dropped and overrun SHALL be set (sticky).
REQ-023 Push and pop on the same edge SHALL both succeed, leaving count unchanged; this SHALL hold when full (no overrun) and SHALL NOT apply when empty (read returns empty, push succeeds).
REQ-024 Pointers SHALL wrap modulo DEPTH; full and empty SHALL be derived from count, never from pointer equality alone.
REQ-025 A flush write SHALL zero the pointers and count on its acceptance edge and SHALL leave overrun unchanged; a push on that same edge SHALL be dropped without setting overrun.
REQ-026 Threshold 0 SHALL be treated as 1, and a threshold greater than DEPTH SHALL be treated as DEPTH.
REQ-027 irq_o SHALL be registered and equal (rx_irq_en & count>=threshold) | (ovr_irq_en & overrun), with one cycle of latency after the causing event.

Reset
REQ-028 Reset SHALL have priority over all other activity, including mid-transfer.
REQ-029 Reset SHALL clear: wb_ack_o=0, wb_dat_o=0, irq_o=0, pointers=0, count=0, overrun=0, rx_irq_en=0, ovr_irq_en=0.
REQ-030 Reset SHALL set threshold to 1.
REQ-031 A bus request in flight during reset SHALL NOT be acknowledged.
REQ-032 FIFO storage contents SHALL NOT need to be reset.

Verification
REQ-033 Push 0x41, 0x42, then read DATA twice, then once more -> 0x041, 0x042, then 0x100; STATUS reads 0x00000001.
REQ-034 DEPTH=16: push 17 bytes 0x00..0x10 -> STATUS = 0x00001006; 16 DATA reads return 0x00..0x0F; write STATUS 0x4 -> overrun cleared.
REQ-035 FIFO full, with rx_dv_i asserted on the same edge as DATA acceptance -> head returned, new byte stored, count stays 16, overrun stays 0.
REQ-036 CTRL = 0x0401 (threshold 4): push 3 bytes -> irq_o=0; 4th push -> irq_o=1 one cycle later; one DATA read -> irq_o=0.
REQ-037 Write CTRL flush with 5 bytes stored and a push on the same edge -> count=0, empty=1, overrun=0, flush reads back 0.
REQ-038 Assert wb_rst_i during the ack cycle of a pending DATA read with 3 bytes stored -> no ack, count=0, irq_o=0, CTRL=0x0100.
